// File: rtl/operand_tf_scheduler.sv
// operand_tf_pkg: beat payloads exchanged with operand_transformer.
// operand_tf_scheduler: round-robin sharing of one operand_transformer between
// NUM_REQ requesters, with an in-order tag FIFO steering results back.
//   clk, rst_n            clock, async active-low reset
//   req_valid/ready/data  per-requester issue beats
//   tf_valid_in/ready_in/data_in    issue side of the transformer
//   tf_valid_out/ready_out/data_out result side of the transformer
//   rsp_valid/ready/data  per-requester results (data broadcast)
//   inflight              tag FIFO occupancy
//   err_orphan            sticky: transformer result with no outstanding tag
package operand_tf_pkg;
    typedef struct packed {
        logic [1:0]  fmt;
        logic [15:0] operand;
    } operand_input_t;

    typedef struct packed {
        logic [1:0]  fmt;
        logic [31:0] value;
    } operand_output_t;
endpackage

module operand_tf_scheduler #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned TAG_DEPTH = 4,
    parameter int unsigned ID_W      = $clog2(NUM_REQ)
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [NUM_REQ-1:0]                            req_valid,
    output logic [NUM_REQ-1:0]                            req_ready,
    input  operand_tf_pkg::operand_input_t [NUM_REQ-1:0]  req_data,
    output logic                                          tf_valid_in,
    input  logic                                          tf_ready_in,
    output operand_tf_pkg::operand_input_t                tf_data_in,
    input  logic                                          tf_valid_out,
    output logic                                          tf_ready_out,
    input  operand_tf_pkg::operand_output_t               tf_data_out,
    output logic [NUM_REQ-1:0]                            rsp_valid,
    input  logic [NUM_REQ-1:0]                            rsp_ready,
    output operand_tf_pkg::operand_output_t               rsp_data,
    output logic [$clog2(TAG_DEPTH):0]                    inflight,
    output logic                                          err_orphan
);
    localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             lock_q, lock_d;
    logic [ID_W-1:0]  lock_id_q, lock_id_d;
    logic [ID_W-1:0]  tag_mem_q [TAG_DEPTH];
    logic [ID_W-1:0]  tag_mem_d [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_orphan_q, err_orphan_d;

    logic             found;
    logic [ID_W-1:0]  arb_id;
    logic [ID_W-1:0]  grant_id;
    logic             have_req;
    logic             full;
    logic             empty;
    logic [ID_W-1:0]  head;
    logic             push;
    logic             pop;

    // Rotating-priority search from rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        found  = 1'b0;
        arb_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[ID_W'((int'(rr_ptr_q) + i) % NUM_REQ)]) begin
                found  = 1'b1;
                arb_id = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            end
        end
    end

    // Issue/return datapath and next-state; outputs are forced low in reset.
    always_comb begin
        full     = (count_q == CNT_W'(TAG_DEPTH));
        empty    = (count_q == '0);
        grant_id = lock_q ? lock_id_q : arb_id;
        have_req = lock_q ? req_valid[lock_id_q] : found;
        head     = tag_mem_q[rd_ptr_q];

        tf_valid_in  = rst_n && have_req && !full;
        tf_data_in   = req_data[grant_id];
        req_ready    = NUM_REQ'(tf_valid_in && tf_ready_in) << grant_id;
        push         = tf_valid_in && tf_ready_in;

        tf_ready_out = rst_n && !empty && rsp_ready[head];
        rsp_valid    = NUM_REQ'(rst_n && tf_valid_out && !empty) << head;
        rsp_data     = tf_data_out;
        pop          = tf_valid_out && tf_ready_out;

        // A stalled offer pins the grant so the transformer sees stable data.
        lock_d    = tf_valid_in && !tf_ready_in;
        lock_id_d = lock_d ? grant_id : lock_id_q;
        rr_ptr_d  = push ? ID_W'((int'(grant_id) + 1) % NUM_REQ) : rr_ptr_q;

        tag_mem_d = tag_mem_q;
        if (push) begin
            tag_mem_d[wr_ptr_q] = grant_id;
        end
        wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
        err_orphan_d = err_orphan_q || (tf_valid_out && empty);

        inflight   = count_q;
        err_orphan = err_orphan_q;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            lock_q       <= 1'b0;
            lock_id_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_orphan_q <= 1'b0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem_q[i] <= '0;
            end
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            lock_q       <= lock_d;
            lock_id_q    <= lock_id_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_orphan_q <= err_orphan_d;
            tag_mem_q    <= tag_mem_d;
        end
    end
endmodule

// File: doc/operand_tf_scheduler.md
Name: operand_tf_scheduler

Overview:
- Round-robin scheduler that shares one operand_transformer between NUM_REQ operand requesters, for example the A- and B-operand fetch streams.
- Arbitrates input beats and records the winner's ID in an in-order tag FIFO.
- Steers each transformer output beat back to the requester that issued it.
- Sits between the operand fetch units and operand_transformer; uses operand_input_t and operand_output_t from operand_tf_pkg.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TAG_DEPTH, 4, maximum in-flight beats; tag FIFO depth, power of two.
- ID_W, $clog2(NUM_REQ), requester ID width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_ready  out  NUM_REQ  per-requester beat accepted.
- req_data  in  NUM_REQ x operand_input_t  per-requester beat.
- tf_valid_in  out  1  to transformer valid_in.
- tf_ready_in  in  1  from transformer ready_in.
- tf_data_in  out  operand_input_t  to transformer data_in.
- tf_valid_out  in  1  from transformer valid_out.
- tf_ready_out  out  1  to transformer ready_out.
- tf_data_out  in  operand_output_t  from transformer data_out.
- rsp_valid  out  NUM_REQ  per-requester result valid.
- rsp_ready  in  NUM_REQ  per-requester result ready.
- rsp_data  out  operand_output_t  result data, broadcast to all requesters; qualified by rsp_valid.
- inflight  out  $clog2(TAG_DEPTH)+1  current tag FIFO occupancy.
- err_orphan  out  1  sticky flag: transformer output arrived with no outstanding tag.

Behaviour:
- Reset (async, rst_n=0): rr_ptr=0, tag FIFO empty, inflight=0, err_orphan=0, no grant locked. All valid/ready outputs are 0; data outputs are don't-care.
- Arbitration (combinational when unlocked):
  - Winner is the first asserted req_valid, searching from rr_ptr upward with wrap.
  - tf_valid_in = any req_valid && inflight<TAG_DEPTH.
  - tf_data_in = req_data[winner].
  - req_ready[winner] = tf_ready_in && inflight<TAG_DEPTH; all other req_ready bits are 0.
- Grant lock:
  - If tf_valid_in=1 and tf_ready_in=0, the winner is registered and held. tf_data_in stays sourced from that requester until acceptance, even if a higher-priority request arrives.
  - The requester must keep req_valid and req_data stable while locked.
  - Lock clears on acceptance.
- Acceptance (tf_valid_in && tf_ready_in):
  - Push winner ID into the tag FIFO.
  - rr_ptr <= (winner+1) mod NUM_REQ.
  - Zero added latency: the issue path is combinational from req to tf.
- FIFO full (inflight==TAG_DEPTH): tf_valid_in=0 and all req_ready=0, regardless of tf_ready_in. A pop in the same cycle does not enable a push (no pop-to-push combinational path).
- Return path:
  - head = tag FIFO head ID.
  - rsp_valid[head] = tf_valid_out && FIFO non-empty; all other rsp_valid bits are 0.
  - rsp_data = tf_data_out.
  - tf_ready_out = rsp_ready[head] && FIFO non-empty.
  - Pop on tf_valid_out && tf_ready_out.
- Simultaneous push and pop: occupancy unchanged; both pointers advance.
- Orphan output: tf_valid_out=1 with FIFO empty sets err_orphan (sticky until reset). tf_ready_out stays 0 and no rsp_valid asserts.
- Ordering: responses return in issue order. The transformer is in-order, so no reordering logic exists.
- Back-pressure: a requester with rsp_ready=0 stalls the return path for all requesters (head-of-line). The issue path continues until the FIFO is full.
- Reset mid-operation: FIFO contents, lock and rr_ptr are discarded. The transformer must be reset in the same cycle.
- inflight wraps only within 0..TAG_DEPTH; pushing when full and popping when empty cannot occur by construction.

Test Plan:
- Both requesters assert valid continuously, transformer always ready → grants alternate 0,1,0,1; rr_ptr toggles each cycle; responses go to rsp_valid[0], [1], [0], [1] in order.
- Req0 valid with tf_ready_in held 0 for 3 cycles, req1 asserts on cycle 2 → tf_data_in stays req0's beat all 3 cycles; on accept, tag 0 is pushed and rr_ptr=1.
- tf_valid_out held 0 while 4 beats are accepted → inflight=4; 5th beat sees tf_valid_in=0 and req_ready=0; one response pop → inflight=3 next cycle, then the 5th beat is accepted.
- Head tag=1 with rsp_ready[1]=0 and rsp_ready[0]=1 → tf_ready_out=0 and rsp_valid[0]=0 until rsp_ready[1]=1; then one pop occurs and inflight decrements.
- Push and pop in the same cycle at inflight=2 → inflight stays 2; response ID order matches issue order.
- tf_valid_out=1 with FIFO empty → err_orphan=1 next cycle and stays 1; tf_ready_out=0. Assert rst_n=0 mid-burst → inflight=0, err_orphan=0, all valids 0 immediately (async).
